// File: rtl/pulse_pkg.sv
// Shared definitions for pulse_gen: FSM state encoding and default counter width.
// Optional burst mode is enabled by defining PULSE_GEN_BURST_EN.
package pulse_pkg;

    localparam int unsigned CNT_W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StHigh = ST_HIGH,
        StGap  = ST_GAP
    } state_t;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector. The delay flop's reset value is a parameter so a level
// held high through reset release can be made to not count as an edge.
module edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_d;

    // Delay flop tracking the previous input level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_d <= RST_VAL;
        end else begin
            din_d <= din;
        end
    end

    assign rise = din & ~din_d;

endmodule

// File: rtl/pulse_gen.sv
// Trigger-to-pulse shaper with guaranteed minimum high width and low holdoff.
// Define PULSE_GEN_BURST_EN to add the n_pulses port (pulses per trigger).
module pulse_gen
    import pulse_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
`ifdef PULSE_GEN_BURST_EN
    input  logic [7:0]       n_pulses,
`endif
    output logic             dout,
    output logic             busy,
    output logic             done,
    output logic             miss
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic             rise;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] gap_q;

`ifdef PULSE_GEN_BURST_EN
    // Width must be kept for reloading on every pulse of a burst
    logic [CNT_W-1:0] width_q;
    logic [7:0]       npl_q;
    logic [7:0]       idx_q;
    logic             last_pulse;

    // idx_q never exceeds npl_q - 1, so the increment cannot wrap
    assign last_pulse = (idx_q + 8'd1) >= npl_q;
`endif

    // Trigger delay flop resets high: a trigger held through reset is not an edge
    edge_det #(
        .RST_VAL(1'b1)
    ) u_edge_det (
        .clk (clk),
        .rst (rst),
        .din (trig),
        .rise(rise)
    );

    assign busy = (state != StIdle);

    // Pulse FSM with down-counter; dout/done/miss are registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            cnt     <= '0;
            gap_q   <= '0;
            dout    <= 1'b0;
            done    <= 1'b0;
            miss    <= 1'b0;
`ifdef PULSE_GEN_BURST_EN
            width_q <= '0;
            npl_q   <= 8'd0;
            idx_q   <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            miss <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Zero-width requests are silently ignored
                    if (rise && (width != '0)) begin
                        state <= StHigh;
                        cnt   <= width;
                        gap_q <= gap;
                        dout  <= 1'b1;
`ifdef PULSE_GEN_BURST_EN
                        width_q <= width;
                        npl_q   <= (n_pulses == 8'd0) ? 8'd1 : n_pulses;
                        idx_q   <= 8'd0;
`endif
                    end
                end
                StHigh: begin
                    if (rise) begin
                        miss <= 1'b1;
                    end
                    if (cnt == CntOne) begin
                        if (gap_q != '0) begin
                            state <= StGap;
                            cnt   <= gap_q;
                            dout  <= 1'b0;
`ifdef PULSE_GEN_BURST_EN
                        end else if (!last_pulse) begin
                            // Zero gap inside a burst: next pulse continues high
                            cnt   <= width_q;
                            idx_q <= idx_q + 8'd1;
`endif
                        end else begin
                            state <= StIdle;
                            cnt   <= '0;
                            dout  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                StGap: begin
                    if (rise) begin
                        miss <= 1'b1;
                    end
                    if (cnt == CntOne) begin
`ifdef PULSE_GEN_BURST_EN
                        if (!last_pulse) begin
                            state <= StHigh;
                            cnt   <= width_q;
                            dout  <= 1'b1;
                            idx_q <= idx_q + 8'd1;
                        end else begin
                            state <= StIdle;
                            cnt   <= '0;
                            done  <= 1'b1;
                        end
`else
                        state <= StIdle;
                        cnt   <= '0;
                        done  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                    dout  <= 1'b0;
                end
            endcase
        end
    end

endmodule
